// File: rtl/mux_arb.sv
// Round-robin arbiter for two requesters in front of the shared 2:1 mux, with a registered output.
// Optional saturating grant counters are built when MUX_ARB_STATS_EN is defined.
module mux_arb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             sel,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_data_q, y_data_d;
    logic             sel_q, sel_d;
    // last_q = 1 when A held the most recent grant
    logic             last_q, last_d;
    logic             load_c;
    logic             grant_a_c, grant_b_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            y_data_q <= '0;
            sel_q    <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            y_data_q <= y_data_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
        end
    end

    // Grant, next-state and datapath select
    always_comb begin
        state_d   = state_q;
        y_data_d  = y_data_q;
        sel_d     = sel_q;
        last_d    = last_q;
        grant_a_c = 1'b0;
        grant_b_c = 1'b0;
        load_c    = (state_q == EMPTY) || y_ready;

        if (load_c) begin
            if (a_valid && b_valid) begin
                grant_a_c = !last_q;
                grant_b_c = last_q;
            end else begin
                grant_a_c = a_valid;
                grant_b_c = b_valid;
            end

            if (grant_a_c) begin
                state_d  = FULL;
                y_data_d = a_data;
                sel_d    = 1'b1;
                last_d   = 1'b1;
            end else if (grant_b_c) begin
                state_d  = FULL;
                y_data_d = b_data;
                sel_d    = 1'b0;
                last_d   = 1'b0;
            end else begin
                state_d  = EMPTY;
            end
        end
    end

    assign a_ready = grant_a_c;
    assign b_ready = grant_b_c;
    assign y_valid = (state_q == FULL);
    assign y_data  = y_data_q;
    assign sel     = sel_q;

`ifdef MUX_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    // Saturating grant counters
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (grant_a_c && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + CNT_W'(1);
        if (grant_b_c && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + CNT_W'(1);
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`else
    assign cnt_a = '0;
    assign cnt_b = '0;
`endif

endmodule

// File: tb/tb_mux_arb.sv
// Self-checking bench for mux_arb: directed scenarios followed by constrained-random traffic
// against a transaction-level reference model.
module tb_mux_arb;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             y_valid;
    logic [WIDTH-1:0] y_data;
    logic             y_ready;
    logic             sel;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    mux_arb #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
        .sel(sel), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: contents of the output slot plus round-robin memory
    bit        m_full;
    bit [31:0] m_data;
    bit        m_sel;
    bit        m_last_was_a;
    int        m_cnt_a;
    int        m_cnt_b;
    bit        acc_a;
    bit        acc_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full       = 0;
        m_data       = '0;
        m_sel        = 0;
        m_last_was_a = 0;
        m_cnt_a      = 0;
        m_cnt_b      = 0;
        acc_a        = 0;
        acc_b        = 0;
    endtask

    // Which requester wins this cycle: 2'b10 = A, 2'b01 = B, 2'b00 = none
    function automatic bit [1:0] model_winner();
        bit room;
        room = !m_full || (y_ready === 1'b1);
        if (!room) return 2'b00;
        if (a_valid && b_valid) return m_last_was_a ? 2'b01 : 2'b10;
        if (a_valid) return 2'b10;
        if (b_valid) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic check_outputs(input string ph);
        chk({ph, "_y_valid"}, 32'(y_valid), 32'(m_full));
        chk({ph, "_y_data"}, y_data, m_data);
        chk({ph, "_sel"}, 32'(sel), 32'(m_sel));
`ifdef MUX_ARB_STATS_EN
        chk({ph, "_cnt_a"}, 32'(cnt_a), 32'(m_cnt_a));
        chk({ph, "_cnt_b"}, 32'(cnt_b), 32'(m_cnt_b));
`else
        chk({ph, "_cnt_a"}, 32'(cnt_a), 32'd0);
        chk({ph, "_cnt_b"}, 32'(cnt_b), 32'd0);
`endif
    endtask

    // One clock: check readies mid-cycle, advance model at the edge, check registered outputs after it
    task automatic cycle(input string ph);
        bit [1:0] w;
        bit       room;
        @(negedge clk);
        w    = model_winner();
        room = !m_full || (y_ready === 1'b1);
        chk({ph, "_a_ready"}, 32'(a_ready), 32'(w[1]));
        chk({ph, "_b_ready"}, 32'(b_ready), 32'(w[0]));
        @(posedge clk);
        acc_a = w[1];
        acc_b = w[0];
        if (room) begin
            if (w[1]) begin
                m_full = 1; m_data = a_data; m_sel = 1; m_last_was_a = 1;
                m_cnt_a = sat_inc(m_cnt_a);
            end else if (w[0]) begin
                m_full = 1; m_data = b_data; m_sel = 0; m_last_was_a = 0;
                m_cnt_b = sat_inc(m_cnt_b);
            end else begin
                m_full = 0;
            end
        end
        #1;
        check_outputs(ph);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_outputs("reset");
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        a_valid = 0; a_data = '0;
        b_valid = 0; b_data = '0;
        y_ready = 0;
        model_reset();
        do_reset();

        // A only, then B only
        a_valid = 1; a_data = 32'hAAAAAAAA; y_ready = 1;
        cycle("a_only");
        chk("a_only_const", y_data, 32'hAAAAAAAA);
        a_valid = 0; b_valid = 1; b_data = 32'h55555555;
        cycle("b_only");
        chk("b_only_sel", 32'(sel), 32'd0);
        b_valid = 0;

        // Reset while FULL drops the word immediately
        y_ready = 0; a_valid = 1; a_data = 32'hAAAAAAAA;
        cycle("pre_rst");
        a_valid = 0;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_y_valid", 32'(y_valid), 32'd0);
        chk("async_rst_y_data", y_data, 32'h0);
        chk("async_rst_sel", 32'(sel), 32'd0);
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        // Tie after reset alternates starting with A
        a_valid = 1; a_data = 32'hA5A5A5A5;
        b_valid = 1; b_data = 32'hFFFFFFFF;
        y_ready = 1;
        for (int i = 0; i < 4; i++) begin
            cycle("tie");
            chk("tie_seq", y_data, (i % 2 == 0) ? 32'hA5A5A5A5 : 32'hFFFFFFFF);
        end

        // Backpressure holding DDDDDDDD loaded from A
        b_valid = 0; a_data = 32'hDDDDDDDD;
        cycle("bp_load");
        a_data = 32'h11111111; b_valid = 1; b_data = 32'h22222222;
        y_ready = 0;
        repeat (3) cycle("bp_hold");
        chk("bp_hold_data", y_data, 32'hDDDDDDDD);
        y_ready = 1;
        cycle("bp_release");
        chk("bp_release_winner", y_data, 32'h22222222);

        // Drain to empty keeps data and sel
        a_valid = 0; b_valid = 0;
        cycle("drain");
        cycle("drain_idle");

        // Counter saturation with 20 consecutive A grants
        do_reset();
        a_valid = 1; a_data = 32'h12345678; y_ready = 1;
        repeat (20) cycle("sat");

        // Constrained-random traffic; requesters hold until accepted
        do_reset();
        a_valid = 0; b_valid = 0;
        for (int i = 0; i < 400; i++) begin
            if (!a_valid || acc_a) begin
                a_valid = 1'($urandom_range(0, 1));
                a_data  = $urandom;
            end
            if (!b_valid || acc_b) begin
                b_valid = 1'($urandom_range(0, 1));
                b_data  = $urandom;
            end
            y_ready = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
